wb_stage_pipelined: RTL and testbench

//  Registered MEM/WB write-back stage. Replaces the combinational result mux.
//  - Latches one retiring instruction with a valid/ready handshake.
//  - Waits a variable number of cycles for load data and aligns it
//    (byte/half/word, signed or unsigned).
//  - Selects ALU result, load data or PC+4 (link) and drives the register-file

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_load_align.sv | 33 +++
 rtl/wb_stage_pipelined.sv | 123 ++++++++++++
 tb/tb_wb_stage_pipelined.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings and FSM state type for the MEM/WB write-back stage.
package wb_pkg;

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_PC4 = 2'd2;

  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: extracts byte/half/word from the raw memory word
// at the given byte offset and sign- or zero-extends it.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  input  logic [1:0]      i_off,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_bsign;
  logic        w_hsign;

  always_comb begin
    w_byte  = i_rdata[{i_off, 3'b000} +: 8];
    // Halfword uses only off[1]; a misaligned off[0] is ignored.
    w_half  = i_off[1] ? i_rdata[16 +: 16] : i_rdata[0 +: 16];
    w_bsign = ~i_unsigned & w_byte[7];
    w_hsign = ~i_unsigned & w_half[15];
    case (i_size)
      LD_B:    o_data = {{(XLEN-8){w_bsign}}, w_byte};
      LD_H:    o_data = {{(XLEN-16){w_hsign}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipelined.sv
// Registered MEM/WB write-back stage: accepts one instruction, waits for load
// data when needed, and drives the register-file write port from registers.
module wb_stage_pipelined
  import wb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_sel,
  input  logic            in_reg_write,
  input  logic [RA_W-1:0] in_rd,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [XLEN-1:0] in_pc_4,
  input  logic [1:0]      in_ld_size,
  input  logic            in_ld_unsigned,
  input  logic [1:0]      in_byte_off,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            timeout_err
);

  wb_state_t        r_state;
  wb_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_reg_write;
  logic [RA_W-1:0]  r_rd;
  logic [1:0]       r_ld_size;
  logic             r_ld_uns;
  logic [1:0]       r_off;

  logic             w_accept;
  logic             w_timeout;
  logic             w_cnt_max;
  logic [XLEN-1:0]  w_in_result;
  logic [XLEN-1:0]  w_ld_data;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .i_rdata    (mem_rdata),
    .i_size     (r_ld_size),
    .i_unsigned (r_ld_uns),
    .i_off      (r_off),
    .o_data     (w_ld_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    in_ready    = (r_state == EMPTY) || (r_state == WRITE);
    w_accept    = in_valid && in_ready;
    w_cnt_max   = (r_cnt == CNT_W'(MAX_WAIT));
    // Reserved select 3 falls through to the ALU result.
    w_in_result = (in_sel == SEL_PC4) ? in_pc_4 : in_alu_out;
    case (r_state)
      EMPTY, WRITE: begin
        if (w_accept) w_state_nxt = (in_sel == SEL_MEM) ? WAIT_MEM : WRITE;
        else          w_state_nxt = EMPTY;
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          w_state_nxt = WRITE;
        end else if (w_cnt_max) begin
          w_state_nxt = EMPTY;
          w_timeout   = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_cnt       <= '0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_ld_size   <= LD_W;
      r_ld_uns    <= 1'b0;
      r_off       <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      timeout_err <= w_timeout;
      rf_we       <= 1'b0;
      if (w_accept) begin
        r_reg_write <= in_reg_write;
        r_rd        <= in_rd;
        r_ld_size   <= in_ld_size;
        r_ld_uns    <= in_ld_unsigned;
        r_off       <= in_byte_off;
        r_cnt       <= '0;
        // Non-load results are known now, so the output registers take them
        // directly and the write appears in the next cycle.
        if (in_sel != SEL_MEM) begin
          rf_we    <= in_reg_write && (in_rd != '0);
          rf_waddr <= in_rd;
          rf_wdata <= w_in_result;
        end
      end
      if (r_state == WAIT_MEM) begin
        if (mem_rvalid) begin
          rf_we    <= r_reg_write && (r_rd != '0);
          rf_waddr <= r_rd;
          rf_wdata <= w_ld_data;
        end else if (!w_cnt_max) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Directed bench for wb_stage_pipelined with a write scoreboard checked on
// every cycle the register-file write enable is high.
module tb_wb_stage_pipelined;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_out;
  logic [31:0] in_pc_4;
  logic [1:0]  in_ld_size;
  logic        in_ld_unsigned;
  logic [1:0]  in_byte_off;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        timeout_err;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  wb_stage_pipelined #(.XLEN(32), .RA_W(5), .MAX_WAIT(15), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sel         (in_sel),
    .in_reg_write   (in_reg_write),
    .in_rd          (in_rd),
    .in_alu_out     (in_alu_out),
    .in_pc_4        (in_pc_4),
    .in_ld_size     (in_ld_size),
    .in_ld_unsigned (in_ld_unsigned),
    .in_byte_off    (in_byte_off),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_we", {31'd0, rf_we}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_waddr", {27'd0, rf_waddr}, {27'd0, e.a});
        chk("sb_wdata", rf_wdata, e.d);
      end
    end
  end

  task automatic drive_op(input logic [1:0] sel, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] pc4);
    in_valid     = 1'b1;
    in_sel       = sel;
    in_reg_write = 1'b1;
    in_rd        = rd;
    in_alu_out   = alu;
    in_pc_4      = pc4;
  endtask

  // Load with rvalid arriving dly cycles after the accept edge (dly >= 1).
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [1:0] size,
                         input logic uns, input logic [1:0] off, input logic [31:0] rdata,
                         input int dly, input logic [31:0] exp);
    drive_op(2'd1, rd, 32'hDEAD_0000, 32'hDEAD_0004);
    in_ld_size     = size;
    in_ld_unsigned = uns;
    in_byte_off    = off;
    mem_rvalid     = 1'b1;
    mem_rdata      = ~rdata;
    step();
    in_valid   = 1'b0;
    mem_rvalid = 1'b0;
    for (int i = 1; i < dly; i++) begin
      chk({tag, "_stall_ready"}, {31'd0, in_ready}, 32'd0);
      step();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    push(rd, exp);
    chk({tag, "_stall_ready"}, {31'd0, in_ready}, 32'd0);
    step();
    mem_rvalid = 1'b0;
    chk({tag, "_we"}, {31'd0, rf_we}, 32'd1);
    chk({tag, "_wdata"}, rf_wdata, exp);
    step();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0; in_sel = 2'd0; in_reg_write = 1'b0; in_rd = '0;
    in_alu_out = '0; in_pc_4 = '0; in_ld_size = 2'd2; in_ld_unsigned = 1'b0;
    in_byte_off = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
    step();
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    step();

    // ALU write one cycle after accept
    drive_op(2'd0, 5'd5, 32'h1234, 32'h0);
    push(5'd5, 32'h1234);
    chk("alu_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("alu_we", {31'd0, rf_we}, 32'd1);
    chk("alu_wdata", rf_wdata, 32'h1234);
    chk("alu_ready_after", {31'd0, in_ready}, 32'd1);
    step();
    chk("alu_we_drop", {31'd0, rf_we}, 32'd0);

    // Link, then link to x0 (no write); reserved select 3 acts as ALU
    drive_op(2'd2, 5'd7, 32'h5555, 32'h400);
    push(5'd7, 32'h400);
    step();
    in_valid = 1'b0;
    chk("link_wdata", rf_wdata, 32'h400);
    step();
    drive_op(2'd2, 5'd0, 32'h5555, 32'h800);
    step();
    in_valid = 1'b0;
    chk("link_x0_we", {31'd0, rf_we}, 32'd0);
    step();
    drive_op(2'd3, 5'd8, 32'hCAFE, 32'h900);
    push(5'd8, 32'hCAFE);
    step();
    in_valid = 1'b0;
    step();

    // Loads: alignment and sign handling
    do_load("lb_s3",  5'd9,  2'd0, 1'b0, 2'd3, 32'h80AABBCC, 3, 32'hFFFFFF80);
    do_load("lhu_2",  5'd10, 2'd1, 1'b1, 2'd2, 32'h80AABBCC, 1, 32'h000080AA);
    do_load("lh_s0",  5'd11, 2'd1, 1'b0, 2'd1, 32'h80AABBCC, 2, 32'hFFFFBBCC);
    do_load("lbu_1",  5'd12, 2'd0, 1'b1, 2'd1, 32'h80AABBCC, 1, 32'h000000BB);
    do_load("lb_s1",  5'd13, 2'd0, 1'b0, 2'd1, 32'h12345678, 1, 32'h00000056);
    do_load("lw",     5'd14, 2'd2, 1'b0, 2'd0, 32'h89ABCDEF, 4, 32'h89ABCDEF);
    do_load("lres",   5'd15, 2'd3, 1'b1, 2'd2, 32'hF00DBEEF, 1, 32'hF00DBEEF);

    // Back-to-back ALU ops write every cycle with no stall
    for (int i = 0; i < 4; i++) begin
      drive_op(2'd0, 5'(16 + i), 32'h100 + 32'(i), 32'h0);
      push(5'(16 + i), 32'h100 + 32'(i));
      chk("b2b_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("b2b_we", {31'd0, rf_we}, 32'd1);
    end
    in_valid = 1'b0;
    step();

    // Timeout: cnt runs 0..15 in WAIT_MEM, so the pulse is registered on the
    // 16th edge after the accept edge.
    drive_op(2'd1, 5'd20, 32'h0, 32'h0);
    in_ld_size = 2'd2;
    step();
    in_valid = 1'b0;
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("to_cycles", 32'(n), 32'd16);
    chk("to_we", {31'd0, rf_we}, 32'd0);
    chk("to_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("to_pulse_end", {31'd0, timeout_err}, 32'd0);

    // Reset while waiting for memory discards the load
    drive_op(2'd1, 5'd21, 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    step();
    rst        = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A5A5A5;
    step();
    chk("rstw_we", {31'd0, rf_we}, 32'd0);
    chk("rstw_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rstw_wdata", rf_wdata, 32'd0);
    chk("rstw_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    step();
    chk("rstw_post_we", {31'd0, rf_we}, 32'd0);
    mem_rvalid = 1'b0;
    step();
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
